bcd_seg_converter: RTL and testbench
====================================

BCD_SEG_CONVERTER -- requirements
Module: bcd_seg_converter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, binary operand width; legal range 4..16.
REQ-002 SHALL have parameter DIGITS, default 3, number of decimal digits and displays; legal range 1..5.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  conversion request, sampled only while ready=1.
REQ-006 SHALL have port binary_in  input  WIDTH  unsigned operand, captured on the accepting edge.
REQ-007 SHALL have port ready  output  1  high only in IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the outputs update.
REQ-009 SHALL have port overflow  output  1  the last operand exceeded 10^DIGITS-1.
REQ-010 SHALL have port bcd  output  4*DIGITS  registered BCD result; digit 0 in bits [3:0].
REQ-011 SHALL have port segs  output  7*DIGITS  registered active-low segments; digit 0 in [6:0]; per-digit bit order {g,f,e,d,c,b,a}.

Function
REQ-012 SHALL implement states IDLE, CONV and DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture binary_in, clear the BCD accumulator, load the iteration counter with WIDTH, latch the overflow compare and move to CONV.
REQ-014 CONV: each edge SHALL add 3 to every accumulator digit >=5, then shift {accumulator, operand} left by one bit (double dabble).
REQ-015 The edge performing shift number WIDTH SHALL move the FSM to DONE.
REQ-016 DONE: the next edge SHALL load bcd/segs/overflow, assert done for exactly one cycle and return to IDLE.
REQ-017 done SHALL be high in the cycle after edge WIDTH+1, counting the accepting edge as edge 0.
REQ-018 Minimum start-to-start period SHALL be WIDTH+2 cycles.
REQ-019 start while not in IDLE SHALL be ignored; no queuing and no effect on the conversion in progress.
REQ-020 bcd, segs and overflow SHALL hold their values between done pulses.
REQ-021 Digit encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-022 On overflow=1: every bcd digit SHALL be 4'hF and every segs digit SHALL be 0111111 (dash).
REQ-023 If 2^WIDTH-1 <= 10^DIGITS-1, overflow SHALL be constant 0.
REQ-024 The accumulator SHALL have enough digits for 2^WIDTH-1; digits above DIGITS are used only for overflow.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, ready=1, done=0, overflow=0, bcd=0 and segs all 1111111, overriding start.
REQ-026 rst during CONV or DONE SHALL abort the conversion with no done pulse; start is accepted from the first edge after rst is released.

Configuration
REQ-027 With LEADING_ZERO_BLANK_EN defined, every zero digit above the most significant non-zero digit SHALL show 1111111; digit 0 is never blanked; bcd and the overflow dash are unaffected.
REQ-028 Without LEADING_ZERO_BLANK_EN, every digit SHALL show its numeral, leading zeros included.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the ten digit segment constants, SEG_BLANK and SEG_DASH.
REQ-030 A combinational sub-module seg7_encoder (4-bit digit plus blank flag in, 7-bit segments out) SHALL be instantiated DIGITS times.

Verification (WIDTH=8, DIGITS=3 unless noted)
REQ-031 Reset, then start with binary_in=0 -> done 9 cycles after acceptance; bcd=12'h000; segs=0/0/0 (blank/blank/0 with macro).
REQ-032 binary_in=255 -> bcd=12'h255; segs digit2=0100100, digit1=0010010, digit0=0010010; overflow=0; exactly one done.
REQ-033 DIGITS=2, binary_in=100 -> overflow=1, bcd=8'hFF, both digits 0111111.
REQ-034 start held high continuously with binary_in=42 -> done every 10 cycles, bcd=12'h042; start pulses mid-CONV change nothing.
REQ-035 rst asserted 4 cycles into CONV -> no done; reset values next cycle; ready=1; a new start converts correctly.
REQ-036 With LEADING_ZERO_BLANK_EN, binary_in=7 -> digit2 and digit1=1111111, digit0=1111000, bcd=12'h007.

Source files
------------

// File: rtl/bcd_seg_converter_pkg.sv
// Shared definitions for the binary-to-BCD seven-segment converter:
// FSM state encoding, active-low digit glyphs ({g,f,e,d,c,b,a}) and
// elaboration-time helpers used to size the BCD accumulator.
package bcd_seg_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Number of decimal digits needed to hold 2^w - 1
    function automatic int dec_digits(input int w);
        int unsigned v;
        int          n;
        v = (32'd1 << w) - 32'd1;
        n = 1;
        for (int i = 0; i < 9; i++) begin
            if (v > 32'd9) begin
                v = v / 32'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    // 10^d for small d
    function automatic int unsigned pow10(input int d);
        int unsigned r;
        r = 32'd1;
        for (int i = 0; i < d; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_seg_converter_seg7_encoder.sv
// Combinational single-digit seven-segment encoder (active-low).
// A set blank flag forces all segments off; codes 10..15 show a dash,
// which is how the converter presents an overflowed digit (4'hF).
module seg7_encoder
    import bcd_seg_converter_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Digit lookup with blank override
    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// driving DIGITS active-low seven-segment displays.
// Latency: accept edge, WIDTH shift edges, one output-load edge.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits
// on the segment outputs (digit 0 always shown; bcd unaffected).
module bcd_seg_converter
    import bcd_seg_converter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary_in,
    output logic                  ready,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   segs
);

    // The accumulator must hold 2^WIDTH-1; any digits beyond DIGITS only
    // ever matter for overflow, which is decided by a direct compare.
    localparam int          NEED_D       = dec_digits(WIDTH);
    localparam int          ACC_D        = (NEED_D > DIGITS) ? NEED_D : DIGITS;
    localparam int          ACC_W        = 4 * ACC_D;
    localparam int          CNT_W        = $clog2(WIDTH + 1);
    localparam logic [31:0] MAX_VAL      = pow10(DIGITS) - 32'd1;
    localparam logic [31:0] OPERAND_MAX  = (32'd1 << WIDTH) - 32'd1;
    localparam bit          OVF_POSSIBLE = (OPERAND_MAX > MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ACC_W-1:0]      r_acc;
    logic [WIDTH-1:0]      r_op;
    logic                  r_ovf_cmp;
    logic                  r_done;
    logic                  r_ovf;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [7*DIGITS-1:0]   r_segs;

    logic [ACC_W-1:0]      w_adj;
    logic [ACC_W+WIDTH-1:0] w_shift;
    logic [31:0]           w_bin_ext;
    logic                  w_ovf_cmp;
    logic [4*DIGITS-1:0]   w_bcd_next;
    logic [DIGITS-1:0]     w_blank;
    logic [7*DIGITS-1:0]   w_segs;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  w_zero_above;
`endif

    assign w_bin_ext = 32'(binary_in);
    assign w_ovf_cmp = OVF_POSSIBLE && (w_bin_ext > MAX_VAL);

    // Double-dabble correction: add 3 to every accumulator digit >= 5
    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < ACC_D; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_shift    = {w_adj, r_op} << 1;
    assign w_bcd_next = r_ovf_cmp ? {(4*DIGITS){1'b1}} : r_acc[4*DIGITS-1:0];

    // Leading-zero blank flags for the display (digit 0 never blanked)
    always_comb begin
        w_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        w_zero_above = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_zero_above = w_zero_above & (w_bcd_next[4*d +: 4] == 4'd0);
            w_blank[d]   = w_zero_above;
        end
`endif
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg7_encoder u_enc (
            .i_digit (w_bcd_next[4*g +: 4]),
            .i_blank (w_blank[g]),
            .o_seg   (w_segs[7*g +: 7])
        );
    end

    // Datapath: capture operand on accept, shift one bit per CONV cycle
    always_ff @(posedge clk) begin
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    r_op      <= binary_in;
                    r_acc     <= '0;
                    r_ovf_cmp <= w_ovf_cmp;
                end
            end
            ST_CONV: begin
                r_acc <= w_shift[ACC_W+WIDTH-1:WIDTH];
                r_op  <= w_shift[WIDTH-1:0];
            end
            default: begin
            end
        endcase
    end

    // Control FSM with registered result outputs and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_bcd   <= '0;
            r_segs  <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= CNT_W'(WIDTH);
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd   <= w_bcd_next;
                    r_segs  <= w_segs;
                    r_ovf   <= r_ovf_cmp;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready    = (r_state == ST_IDLE);
    assign done     = r_done;
    assign overflow = r_ovf;
    assign bcd      = r_bcd;
    assign segs     = r_segs;

endmodule

// File: tb/tb_bcd_seg_converter.sv
// Directed bench for bcd_seg_converter: a WIDTH=8/DIGITS=3 instance driven
// from a vector table plus hand-written corner sequences, and a
// WIDTH=8/DIGITS=2 instance for the overflow display.
module tb_bcd_seg_converter;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic [20:0] segs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, start2;
    logic [7:0]  binary_in, bin2;
    logic        ready, done, overflow;
    logic [11:0] bcd;
    logic [20:0] segs;
    logic        ready2, done2, overflow2;
    logic [7:0]  bcd2;
    logic [13:0] segs2;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[10];

    always #5 clk = ~clk;

    bcd_seg_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .binary_in (binary_in),
        .ready     (ready),
        .done      (done),
        .overflow  (overflow),
        .bcd       (bcd),
        .segs      (segs)
    );

    bcd_seg_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .binary_in (bin2),
        .ready     (ready2),
        .done      (done2),
        .overflow  (overflow2),
        .bcd       (bcd2),
        .segs      (segs2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Start a conversion on dut from a negedge; return at the negedge where
    // done is seen, lat = number of edges after the accepting edge.
    task automatic convert(input logic [7:0] v, output int lat);
        chk("ready_idle", 32'(ready), 32'd1);
        binary_in = v;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        chk("ready_low_conv", 32'(ready), 32'd0);
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convert2(input logic [7:0] v, output int lat);
        bin2   = v;
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        lat    = 0;
        while (done2 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_done;
        int last;

        vecs[0] = '{8'd0,   12'h000, {LZ, LZ, S0}};
        vecs[1] = '{8'd255, 12'h255, {S2, S5, S5}};
        vecs[2] = '{8'd42,  12'h042, {LZ, S4, S2}};
        vecs[3] = '{8'd7,   12'h007, {LZ, LZ, S7}};
        vecs[4] = '{8'd100, 12'h100, {S1, S0, S0}};
        vecs[5] = '{8'd99,  12'h099, {LZ, S9, S9}};
        vecs[6] = '{8'd128, 12'h128, {S1, S2, S8}};
        vecs[7] = '{8'd203, 12'h203, {S2, S0, S3}};
        vecs[8] = '{8'd36,  12'h036, {LZ, S3, S6}};
        vecs[9] = '{8'd10,  12'h010, {LZ, S1, S0}};

        // Reset with start asserted: reset must win
        rst = 1'b1; start = 1'b1; binary_in = 8'hAA; start2 = 1'b1; bin2 = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready",    32'(ready),    32'd1);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_bcd",      32'(bcd),      32'h000);
        chk("rst_segs",     32'(segs),     32'h1F_FFFF);
        chk("rst_ready2",   32'(ready2),   32'd1);
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        @(negedge clk);

        // Table-driven conversions
        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bin, lat);
            chk($sformatf("lat[%0d]", i),  32'(lat),      32'd9);
            chk($sformatf("bcd[%0d]", i),  32'(bcd),      32'(vecs[i].bcd));
            chk($sformatf("segs[%0d]", i), 32'(segs),     32'(vecs[i].segs));
            chk($sformatf("ovf[%0d]", i),  32'(overflow), 32'd0);
            @(negedge clk);
            chk($sformatf("done_pulse[%0d]", i), 32'(done), 32'd0);
            chk($sformatf("bcd_hold[%0d]", i),   32'(bcd),  32'(vecs[i].bcd));
        end

        // Start pulses and operand changes mid-CONV are ignored
        binary_in = 8'd200;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            start     = (lat == 3 || lat == 5);
            binary_in = (lat >= 3) ? 8'd17 : 8'd200;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("midconv_lat",  32'(lat),  32'd9);
        chk("midconv_bcd",  32'(bcd),  32'h200);
        chk("midconv_segs", 32'(segs), 32'({S2, S0, S0}));
        n_done = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midconv_no_queue", 32'(n_done), 32'd0);
        chk("midconv_ready",    32'(ready),  32'd1);

        // Start held high: back-to-back conversions every WIDTH+2 cycles
        binary_in = 8'd42;
        start     = 1'b1;
        n_done    = 0;
        last      = -1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("held_period", 32'(c - last), 32'd10);
                chk("held_bcd", 32'(bcd), 32'h042);
                last = c;
                n_done++;
            end
        end
        start = 1'b0;
        chk("held_count", 32'(n_done), 32'd4);
        repeat (12) @(negedge clk);

        // DIGITS=2 instance: in range, then overflow
        convert2(8'd99, lat);
        chk("d2_lat",      32'(lat),       32'd9);
        chk("d2_99_bcd",   32'(bcd2),      32'h99);
        chk("d2_99_segs",  32'(segs2),     32'({S9, S9}));
        chk("d2_99_ovf",   32'(overflow2), 32'd0);
        @(negedge clk);
        convert2(8'd100, lat);
        chk("d2_100_ovf",  32'(overflow2), 32'd1);
        chk("d2_100_bcd",  32'(bcd2),      32'hFF);
        chk("d2_100_segs", 32'(segs2),     32'({SD, SD}));
        @(negedge clk);
        chk("d2_ovf_hold", 32'(overflow2), 32'd1);

        // Reset four edges into CONV aborts without a done pulse
        binary_in = 8'd123;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_conv", 32'(ready), 32'd0);
        rst = 1'b1; start = 1'b1; start2 = 1'b1;
        @(negedge clk);
        chk("abort_done",   32'(done),      32'd0);
        chk("abort_ready",  32'(ready),     32'd1);
        chk("abort_bcd",    32'(bcd),       32'h000);
        chk("abort_segs",   32'(segs),      32'h1F_FFFF);
        chk("abort_ovf2",   32'(overflow2), 32'd0);
        chk("abort_bcd2",   32'(bcd2),      32'h00);
        chk("abort_segs2",  32'(segs2),     32'h3FFF);
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        n_done = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        convert(8'd58, lat);
        chk("post_abort_lat",  32'(lat),  32'd9);
        chk("post_abort_bcd",  32'(bcd),  32'h058);
        chk("post_abort_segs", 32'(segs), 32'({LZ, S5, S8}));
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
